elut_config_writer: RTL and testbench



---
 rtl/elut_config_writer_pkg.sv | 24 ++
 rtl/elut_config_writer_if.sv | 33 +++
 rtl/elut_cfg_shifter.sv | 51 +++++
 rtl/elut_config_writer.sv | 122 ++++++++++++
 tb/tb_elut_config_writer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/elut_config_writer_pkg.sv
// Shared definitions for the ZUMA LUTRAM configuration writer.
//   - FSM state encoding (2 bits)
//   - LUTRAM write-address width
//   - words_per_lut(): configuration words needed to fill one LUT mask
`ifndef ZUMA_LUT_SIZE
`define ZUMA_LUT_SIZE 6
`endif

package elut_config_writer_pkg;

  // LUTRAM address port is always 6 bits wide; narrower LUTs zero-extend.
  localparam int unsigned LutAddrW = 6;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  function automatic int unsigned words_per_lut(input int unsigned lut_size,
                                                input int unsigned cfg_width);
    return (32'd1 << lut_size) / cfg_width;
  endfunction

endpackage

// File: rtl/elut_config_writer_if.sv
// Bus between the configuration controller and the LUTRAM write column.
//   start            : one-cycle pulse, begins a programming pass
//   cfg_data/valid   : configuration word stream, cfg_ready is the writer's accept
//   lut_a/lut_d      : shared LUTRAM write address / data
//   lut_we           : one-hot write enable, one bit per LUTRAM wrapper
//   busy/done        : pass status
// master = controller/LUTRAM side, slave = writer.
interface elut_config_writer_if
  import elut_config_writer_pkg::*;
#(
  parameter int unsigned CFG_WIDTH = 32,
  parameter int unsigned NUM_LUTS  = 8
);
  logic                 start;
  logic [CFG_WIDTH-1:0] cfg_data;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [LutAddrW-1:0]  lut_a;
  logic                 lut_d;
  logic [NUM_LUTS-1:0]  lut_we;
  logic                 busy;
  logic                 done;

  modport master (
    output start, cfg_data, cfg_valid,
    input  cfg_ready, lut_a, lut_d, lut_we, busy, done
  );

  modport slave (
    input  start, cfg_data, cfg_valid,
    output cfg_ready, lut_a, lut_d, lut_we, busy, done
  );
endinterface

// File: rtl/elut_cfg_shifter.sv
// Load/shift register for one configuration word.
//   clk, rst : clock, synchronous active-high reset
//   load_i   : capture data_i and clear the bit counter
//   data_i   : configuration word, bit 0 leaves first
//   shift_i  : shift right by one (zero fill), advance bit counter
//   bit_o    : current bit to be written (register bit 0)
//   last_o   : current bit is the last one of the word
module elut_cfg_shifter #(
  parameter int unsigned CFG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [CFG_WIDTH-1:0] data_i,
  input  logic                 shift_i,
  output logic                 bit_o,
  output logic                 last_o
);
  localparam int unsigned CntW = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;

  logic [CFG_WIDTH-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      sreg_d = data_i;
      cnt_d  = '0;
    end else if (shift_i) begin
      // Zero fill leaves the register clear once a word is drained, so the
      // bit output idles low outside write cycles.
      sreg_d = sreg_q >> 1;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bit_o  = sreg_q[0];
  assign last_o = (cnt_q == CntW'(CFG_WIDTH - 1));

endmodule

// File: rtl/elut_config_writer.sv
// Write-side driver for a column of ZUMA LUTRAM wrappers. Serialises each LUT
// mask, one bit per cycle, onto the shared a/d port with a one-hot write enable,
// programming NUM_LUTS wrappers in turn, then pulses done.
//   clk, rst : clock (also the LUTRAM write clock), synchronous active-high reset
//   bus      : slave side of elut_config_writer_if (start, cfg stream, LUT port,
//              busy/done)
module elut_config_writer
  import elut_config_writer_pkg::*;
#(
  parameter int unsigned ZUMA_LUT_SIZE = `ZUMA_LUT_SIZE,
  parameter int unsigned NUM_LUTS      = 8,
  parameter int unsigned CFG_WIDTH     = 32
) (
  input logic                 clk,
  input logic                 rst,
  elut_config_writer_if.slave bus
);
  localparam int unsigned MaskBits = 32'd1 << ZUMA_LUT_SIZE;
  localparam int unsigned IdxW     = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;

  if (ZUMA_LUT_SIZE < 1 || ZUMA_LUT_SIZE > 6) begin : g_bad_lut_size
    $error("elut_config_writer: ZUMA_LUT_SIZE must be 1..6");
  end
  if (words_per_lut(ZUMA_LUT_SIZE, CFG_WIDTH) * CFG_WIDTH != MaskBits) begin : g_bad_cfg_width
    $error("elut_config_writer: CFG_WIDTH must divide 2**ZUMA_LUT_SIZE");
  end

  logic [1:0]               state_q, state_d;
  logic [ZUMA_LUT_SIZE-1:0] addr_q, addr_d;
  logic [IdxW-1:0]          lut_idx_q, lut_idx_d;
  logic [NUM_LUTS-1:0]      lut_we_q, lut_we_d;
  logic                     cfg_ready_q, cfg_ready_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic sh_load, sh_shift, sh_bit, sh_last;
  logic lut_end;

  elut_cfg_shifter #(
    .CFG_WIDTH (CFG_WIDTH)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load_i  (sh_load),
    .data_i  (bus.cfg_data),
    .shift_i (sh_shift),
    .bit_o   (sh_bit),
    .last_o  (sh_last)
  );

  // Last bit of the mask; the address counter wraps to 0 on the same edge.
  assign lut_end = (addr_q == {ZUMA_LUT_SIZE{1'b1}});

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lut_idx_d = lut_idx_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;

    case (state_q)
      StIdle: begin
        addr_d    = '0;
        lut_idx_d = '0;
        if (bus.start) state_d = StLoad;
      end
      StLoad: begin
        if (bus.cfg_valid && cfg_ready_q) begin
          sh_load = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        sh_shift = 1'b1;
        addr_d   = addr_q + 1'b1;
        if (sh_last) begin
          state_d = StLoad;
          if (lut_end) begin
            if (lut_idx_q == IdxW'(NUM_LUTS - 1)) state_d = StDone;
            else                                  lut_idx_d = lut_idx_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with it.
    cfg_ready_d = (state_d == StLoad);
    busy_d      = (state_d == StLoad) || (state_d == StWrite);
    done_d      = (state_d == StDone);
    lut_we_d    = (state_d == StWrite) ? (NUM_LUTS'(1) << lut_idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      lut_idx_q   <= '0;
      lut_we_q    <= '0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lut_idx_q   <= lut_idx_d;
      lut_we_q    <= lut_we_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.lut_a     = LutAddrW'(addr_q);
  assign bus.lut_d     = sh_bit;
  assign bus.lut_we    = lut_we_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_elut_config_writer.sv
// Directed bench for elut_config_writer: a 6-input/32-bit-word instance and a
// 4-input/16-bit-word instance, each with a behavioural LUTRAM model.
module tb_elut_config_writer;
  import elut_config_writer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  elut_config_writer_if #(.CFG_WIDTH(32), .NUM_LUTS(2)) bus ();
  elut_config_writer_if #(.CFG_WIDTH(16), .NUM_LUTS(2)) bus4 ();

  elut_config_writer #(.ZUMA_LUT_SIZE(6), .NUM_LUTS(2), .CFG_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  elut_config_writer #(.ZUMA_LUT_SIZE(4), .NUM_LUTS(2), .CFG_WIDTH(16)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  // LUTRAM models and a free-running cycle counter.
  logic [63:0] lram  [2];
  logic [15:0] lram4 [2];
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (bus.lut_we[i])  lram[i][bus.lut_a]       <= bus.lut_d;
      if (bus4.lut_we[i]) lram4[i][bus4.lut_a[3:0]] <= bus4.lut_d;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] words [4];
  int done_len, done_cnt, n_wr;

  // One pass on the 6-input instance. cfg_valid is held high except for
  // stall_len LOAD cycles in front of word stall_word.
  task automatic run_pass(input int stall_word, input int stall_len, input bit repulse,
                          input bit rst_mid);
    int wptr, stall_left, n, start_cyc, after_done;
    bit prev_ready, prev_valid, finished, rst_pending;
    wptr = 0; stall_left = stall_len; n = 0; after_done = 0;
    prev_ready = 1'b0; prev_valid = 1'b0; finished = 1'b0; rst_pending = 1'b0;
    done_cnt = 0; done_len = -1;
    bus.start     = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = words[0];
    start_cyc     = cyc;
    for (int t = 0; t < 400 && !finished; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (rst_pending) begin
        chk("rst_mid_outputs", {bus.cfg_ready, bus.lut_a, bus.lut_d, bus.lut_we,
                                bus.busy, bus.done}, 0);
        rst = 1'b0;
        finished = 1'b1;
      end else begin
        if (prev_ready && prev_valid) wptr++;
        if (bus.done) begin
          done_cnt++;
          if (done_len < 0) done_len = cyc - start_cyc + 1;
          chk("done_cycle_idle", {bus.busy, bus.lut_we}, 0);
          if (repulse) bus.start = 1'b1;
        end
        if (done_cnt > 0 && !bus.done)
          chk("idle_after_done", {bus.busy, bus.cfg_ready, bus.lut_we}, 0);
        if (bus.lut_we != 0) begin
          if (n < 128) begin
            chk("we_onehot", bus.lut_we, 2'b01 << (n / 64));
            chk("addr", bus.lut_a, n % 64);
            chk("d_bit", bus.lut_d, words[n / 32][n % 32]);
            chk("ready_in_write", bus.cfg_ready, 0);
          end else begin
            chk("extra_write", bus.lut_we, 0);
          end
          n++;
          if (repulse && n == 20) bus.start = 1'b1;
          if (rst_mid && n == 64 + 11) begin
            rst = 1'b1;
            rst_pending = 1'b1;
          end
        end
        if (bus.cfg_ready && wptr == stall_word && stall_left > 0) begin
          chk("stall_we", bus.lut_we, 0);
          bus.cfg_valid = 1'b0;
          stall_left--;
        end else begin
          bus.cfg_valid = 1'b1;
        end
        bus.cfg_data = (wptr < 4) ? words[wptr] : 32'h0;
        prev_ready = bus.cfg_ready;
        prev_valid = bus.cfg_valid;
        if (done_cnt > 0) after_done++;
        if (after_done > 8) finished = 1'b1;
      end
    end
    chk("pass_finished", finished, 1);
    n_wr = n;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] w4s [2];
    int w4, n4, sc4, done4;
    bit pr4;

    words[0] = 32'hDEADBEEF; words[1] = 32'h12345678;
    words[2] = 32'hFFFFFFFF; words[3] = 32'h00000001;
    w4s[0] = 16'hBEEF; w4s[1] = 16'h1234;

    // 1. Reset held with start high.
    rst = 1'b1;
    bus.start = 1'b1;  bus.cfg_valid = 1'b0;  bus.cfg_data = '0;
    bus4.start = 1'b1; bus4.cfg_valid = 1'b0; bus4.cfg_data = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_outputs", {bus.cfg_ready, bus.lut_a, bus.lut_d, bus.lut_we,
                          bus.busy, bus.done}, 0);
      chk("rst_outputs4", {bus4.cfg_ready, bus4.lut_a, bus4.lut_d, bus4.lut_we,
                           bus4.busy, bus4.done}, 0);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    bus4.start = 1'b0;
    @(negedge clk);
    chk("no_pass_after_rst", {bus.busy, bus4.busy}, 0);

    // 2. Full pass.
    run_pass(-1, 0, 1'b0, 1'b0);
    chk("writes", n_wr, 128);
    chk("done_cycle", done_len, 134);
    chk("done_pulses", done_cnt, 1);
    chk("lut0_mask", lram[0], 64'h12345678DEADBEEF);
    chk("lut1_mask", lram[1], 64'h00000001FFFFFFFF);
    chk("lut0_dpra5", lram[0][5], 1);
    chk("lut1_dpra33", lram[1][33], 0);

    // 3. Backpressure before word 2.
    run_pass(2, 5, 1'b0, 1'b0);
    chk("bp_writes", n_wr, 128);
    chk("bp_done_cycle", done_len, 139);
    chk("bp_lut1_mask", lram[1], 64'h00000001FFFFFFFF);

    // 4. start re-pulsed during WRITE and DONE.
    run_pass(-1, 0, 1'b1, 1'b0);
    chk("rp_writes", n_wr, 128);
    chk("rp_done_cycle", done_len, 134);
    chk("rp_done_pulses", done_cnt, 1);
    chk("rp_lut0_mask", lram[0], 64'h12345678DEADBEEF);

    // 5. Reset during LUT1 write at a=10, then a fresh pass.
    run_pass(-1, 0, 1'b0, 1'b1);
    chk("rm_writes", n_wr, 75);
    chk("rm_no_done", done_cnt, 0);
    run_pass(-1, 0, 1'b0, 1'b0);
    chk("rm2_writes", n_wr, 128);
    chk("rm2_done_cycle", done_len, 134);
    chk("rm2_lut0_mask", lram[0], 64'h12345678DEADBEEF);
    chk("rm2_lut1_mask", lram[1], 64'h00000001FFFFFFFF);

    // 6. 4-input LUTs, 16-bit words.
    w4 = 0; n4 = 0; pr4 = 1'b0; done4 = -1;
    bus4.start = 1'b1; bus4.cfg_valid = 1'b1; bus4.cfg_data = w4s[0];
    sc4 = cyc;
    for (int t = 0; t < 100 && done4 < 0; t++) begin
      @(negedge clk);
      bus4.start = 1'b0;
      if (pr4) w4++;
      chk("a4_hi_zero", bus4.lut_a[5:4], 0);
      if (bus4.lut_we != 0) begin
        if (n4 < 32) begin
          chk("a4_addr", bus4.lut_a[3:0], n4 % 16);
          chk("we4_onehot", bus4.lut_we, 2'b01 << (n4 / 16));
        end
        n4++;
      end
      if (bus4.done) done4 = cyc - sc4 + 1;
      bus4.cfg_data = (w4 < 2) ? w4s[w4] : 16'h0;
      pr4 = bus4.cfg_ready;
    end
    @(negedge clk);
    chk("w4_writes", n4, 32);
    chk("w4_done_cycle", done4, 36);
    chk("w4_lut0_mask", lram4[0], 16'hBEEF);
    chk("w4_lut1_mask", lram4[1], 16'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
